pia_bus_master: RTL

//  Bus initiator for the MC6820 PIA register interface: turns single-beat requests from
//  the host/CPU side into timed PIA cycles (CS/RS/rw/enable/DI) and returns captured DO.

---
 rtl/pia_bus_master.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pia_bus_master.sv
// pia_bus_master: host-side initiator for the MC6820 PIA register port.
// Each host request becomes exactly one timed PIA cycle: SETUP, ENABLE and HOLD.
// A read returns the PIA DO value captured at the end of ENABLE; a write returns 0.
// The PIA interrupt lines are synchronised separately into irq_pending.
// Timing: the accept edge drives the bus. rsp_valid rises on the edge that follows
// SETUP_CYC+ENABLE_CYC+HOLD_CYC cycles, which is the (SETUP+ENABLE+HOLD+1)th edge
// when the accept edge is counted as the first.
module pia_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned ENABLE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter logic [2:0]  CS_SEL     = 3'b011,
  parameter logic [2:0]  CS_IDLE    = 3'b100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_rs,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [2:0] pia_cs,
  output logic [1:0] pia_rs,
  output logic       pia_rw,
  output logic       pia_enable,
  output logic [7:0] pia_di,
  input  logic [7:0] pia_do,
  input  logic       pia_irqa_n,
  input  logic       pia_irqb_n,
  output logic       irq_pending
);

  // The phase counter is 4 bits wide, so longer phases cannot be represented.
  if (SETUP_CYC > 15 || ENABLE_CYC > 15 || HOLD_CYC > 15 || ENABLE_CYC < 1) begin : g_bad_param
    $error("pia_bus_master: phase lengths must be 0..15 (ENABLE_CYC 1..15)");
  end

  // Counter reload values (phase length - 1). A zero-length phase is skipped.
  localparam int unsigned SetupLoad  = (SETUP_CYC > 0) ? SETUP_CYC - 1 : 0;
  localparam int unsigned EnableLoad = ENABLE_CYC - 1;
  localparam int unsigned HoldLoad   = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ENABLE,
    S_HOLD,
    S_RESP
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] cs_q, cs_d;
  logic [1:0] rs_q, rs_d;
  logic       rw_q, rw_d;
  logic       en_q, en_d;
  logic [7:0] di_q, di_d;
  logic       rspv_q, rspv_d;
  logic [7:0] rdata_q, rdata_d;
  logic [1:0] irqa_sync_q, irqb_sync_q;
  logic       irq_q;

  // Next-state and next bus values for the cycle sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    en_d    = en_q;
    di_d    = di_q;
    rspv_d  = rspv_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cs_d = CS_SEL;
          rs_d = req_rs;
          rw_d = req_write;
          di_d = req_write ? req_wdata : 8'h00;
          if (SETUP_CYC == 0) begin
            en_d    = 1'b1;
            cnt_d   = 4'(EnableLoad);
            state_d = S_ENABLE;
          end else begin
            cnt_d   = 4'(SetupLoad);
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          en_d    = 1'b1;
          cnt_d   = 4'(EnableLoad);
          state_d = S_ENABLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ENABLE: begin
        if (cnt_q == 4'd0) begin
          en_d    = 1'b0;
          rdata_d = rw_q ? 8'h00 : pia_do;
          if (HOLD_CYC == 0) begin
            cs_d    = CS_IDLE;
            rw_d    = 1'b0;
            di_d    = 8'h00;
            rspv_d  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(HoldLoad);
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          cs_d    = CS_IDLE;
          rw_d    = 1'b0;
          di_d    = 8'h00;
          rspv_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rspv_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer and bus registers; reset abandons any cycle in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      cs_q    <= CS_IDLE;
      rs_q    <= 2'b00;
      rw_q    <= 1'b0;
      en_q    <= 1'b0;
      di_q    <= 8'h00;
      rspv_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      en_q    <= en_d;
      di_q    <= di_d;
      rspv_q  <= rspv_d;
      rdata_q <= rdata_d;
    end
  end

  // Two-flop synchronisers on both interrupt lines plus a registered OR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqa_sync_q <= 2'b00;
      irqb_sync_q <= 2'b00;
      irq_q       <= 1'b0;
    end else begin
      irqa_sync_q <= {irqa_sync_q[0], ~pia_irqa_n};
      irqb_sync_q <= {irqb_sync_q[0], ~pia_irqb_n};
      irq_q       <= irqa_sync_q[1] | irqb_sync_q[1];
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rspv_q;
  assign rsp_rdata   = rdata_q;
  assign pia_cs      = cs_q;
  assign pia_rs      = rs_q;
  assign pia_rw      = rw_q;
  assign pia_enable  = en_q;
  assign pia_di      = di_q;
  assign irq_pending = irq_q;

endmodule
